ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the RISC-TOY 5-stage pipeline; consumes the ID/EX register outputs and produces the registered EX/MEM pipeline state.
- Contains operand forwarding muxes, a single-cycle ALU and shifter, and branch/jump resolution.
- Contains an iterative 32-cycle unsigned multiplier (custom IP op). While the multiplier runs, the block stalls the upstream stages.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations (equals the data width; fixed at 32).

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset
- RegWrite_EX, Branch_EX, Jump_EX, rb1111check_EX  in  1 each  ID/EX control
- MemRW_EX  in  3  ID/EX control
- ALUSrc_EX, ResultSrc_EX, LoadStoreSrc_EX  in  2 each  ID/EX control
- ALUControl_EX  in  4  ID/EX control
- shift_amount_EX  in  6  ID/EX control
- BR_cond_EX  in  3  ID/EX control
- PC_EX, RD1_EX, RD2_EX, immExtend_EX  in  32 each  ID/EX data
- ra_EX, rb_EX, rac_EX  in  5 each  register indices; ra is the destination
- RegWrite_WB  in  1  WB-stage write enable
- ra_WB  in  5  WB-stage destination
- Result_WB  in  32  WB-stage write data
- stall_EX  out  1  to hazard unit; stalls PC, IF/ID and ID/EX
- br_taken  out  1  redirect PC; flushes IF/ID and ID/EX
- br_target  out  32  redirect address
- RegWrite_MEM  out  1  EX/MEM register
- MemRW_MEM  out  3  EX/MEM register
- ResultSrc_MEM, LoadStoreSrc_MEM  out  2 each  EX/MEM register
- ALUResult_MEM, WriteData_MEM, PC4_MEM  out  32 each  EX/MEM register
- ra_MEM  out  5  EX/MEM register

Behaviour:
- Reset:
  - RSTN is asynchronous, active-low; clock is CLK.
  - On reset, all *_MEM outputs go to 0 and the multiplier FSM goes to IDLE.
  - stall_EX and br_taken are combinational; both evaluate to 0 in reset.
- Forwarding, per source (rb→A, rac→B):
  - If RegWrite_MEM and ra_MEM==src, use ALUResult_MEM.
  - Else if RegWrite_WB and ra_WB==src, use Result_WB.
  - Else use RD1_EX/RD2_EX.
  - Register 0 is not special-cased.
- Operand A: 0 if rb1111check_EX=1, else the forwarded rb value.
- Operand B by ALUSrc_EX:
  - 00: forwarded rac value.
  - 01: immExtend_EX.
  - 10: zero-extended shift_amount_EX.
  - 11: 0.
- ALUControl_EX, all 32-bit with wrap-around:
  - 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR, 0101 NOT B.
  - Shifts use amt = B[4:0]: 0110 SHR logical, 0111 SHR arithmetic, 1000 SHL, 1001 ROR.
  - 1010 MUL: low 32 bits of unsigned A*B.
  - 1111 NOP: result 0.
  - Any other code gives result 0.
- Branch/jump, evaluated on the forwarded rac value (cv), combinational:
  - Condition by BR_cond_EX: 000 never, 001 always, 010 cv==0, 011 cv!=0, 100 cv[31]==0, 101 cv[31]==1, others never.
  - br_taken = Jump_EX | (Branch_EX & cond).
  - br_target = forwarded rb value if Jump_EX, else PC_EX+immExtend_EX.
  - br_taken is forced 0 while stall_EX=1.
- Multiplier FSM:
  - IDLE: when ALUControl_EX==1010, latch A and B (forwarded values, since MEM/WB drain during the stall), clear acc and cnt, go to BUSY. stall_EX=1 in this cycle.
  - BUSY: each cycle, if B_l[0] then acc+=A_l; then A_l<<=1, B_l>>=1, cnt++. stall_EX=1. When cnt reaches MUL_CYCLES-1 (last iteration done), go to DONE.
  - DONE: stall_EX=0; result = acc. EX/MEM captures the MUL instruction on this edge; next state IDLE.
  - Total: 33 stalled cycles plus the 1 DONE cycle, so the MUL occupies EX for 34 cycles.
  - A MUL arriving in the cycle right after DONE starts a new operation; no lockout.
  - Reset mid-operation aborts to IDLE with the accumulator discarded.
- EX/MEM register, every posedge unless in reset:
  - If stall_EX=1, load a bubble: RegWrite_MEM=0, MemRW_MEM=000, all others 0.
  - Otherwise load the ID/EX controls, ALU result, WriteData_MEM=forwarded rac value, PC4_MEM=PC_EX+4, ra_MEM=ra_EX.
  - A bubble arriving from ID/EX (ALUControl 1111, RegWrite 0) passes through as a bubble.

Test Plan:
- Forwarding priority: ADD r1 (ALUResult_MEM=5), WB r1=9, next ADD r2=r1+r1 with RD1_EX=0 → ALUResult_MEM=10.
- MUL: A=0x0001_0003, B=7 → stall_EX high for exactly 33 cycles; then ALUResult_MEM=0x0007_0015 with RegWrite_MEM=1; bubbles in EX/MEM during the stall.
- MUL overflow: A=B=0xFFFF_FFFF → ALUResult_MEM=0x0000_0001.
- Branch: Branch_EX=1, BR_cond=010, cv=0, PC_EX=0x100, imm=0x20 → br_taken=1, br_target=0x120. Same with cv=3 → br_taken=0.
- Shifts: A=0x8000_0000, ALUSrc=10, shift_amount=4 → SHRA result 0xF800_0000, SHR 0x0800_0000, ROR 0x0800_0000.
- Reset asserted at BUSY cycle 10 → all *_MEM outputs 0 and stall_EX=0 immediately. After release, a fresh MUL takes the full 33-cycle stall.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX inputs, WB forwarding inputs and EX/MEM outputs of the execute stage.
// Latency: n/a (signal bundle only).
// Backpressure: stall_EX travels back towards the hazard unit on this bundle.
interface ex_stage_if;
  // ID/EX control and data
  logic        RegWrite_EX;
  logic        Branch_EX;
  logic        Jump_EX;
  logic        rb1111check_EX;
  logic [2:0]  MemRW_EX;
  logic [1:0]  ALUSrc_EX;
  logic [1:0]  ResultSrc_EX;
  logic [1:0]  LoadStoreSrc_EX;
  logic [3:0]  ALUControl_EX;
  logic [5:0]  shift_amount_EX;
  logic [2:0]  BR_cond_EX;
  logic [31:0] PC_EX;
  logic [31:0] RD1_EX;
  logic [31:0] RD2_EX;
  logic [31:0] immExtend_EX;
  logic [4:0]  ra_EX;
  logic [4:0]  rb_EX;
  logic [4:0]  rac_EX;
  // WB-stage write port, used for forwarding
  logic        RegWrite_WB;
  logic [4:0]  ra_WB;
  logic [31:0] Result_WB;
  // Hazard / redirect
  logic        stall_EX;
  logic        br_taken;
  logic [31:0] br_target;
  // EX/MEM register
  logic        RegWrite_MEM;
  logic [2:0]  MemRW_MEM;
  logic [1:0]  ResultSrc_MEM;
  logic [1:0]  LoadStoreSrc_MEM;
  logic [31:0] ALUResult_MEM;
  logic [31:0] WriteData_MEM;
  logic [31:0] PC4_MEM;
  logic [4:0]  ra_MEM;

  // Pipeline side: drives ID/EX and WB, observes EX results
  modport master (
    output RegWrite_EX, Branch_EX, Jump_EX, rb1111check_EX, MemRW_EX,
           ALUSrc_EX, ResultSrc_EX, LoadStoreSrc_EX, ALUControl_EX,
           shift_amount_EX, BR_cond_EX, PC_EX, RD1_EX, RD2_EX, immExtend_EX,
           ra_EX, rb_EX, rac_EX, RegWrite_WB, ra_WB, Result_WB,
    input  stall_EX, br_taken, br_target, RegWrite_MEM, MemRW_MEM,
           ResultSrc_MEM, LoadStoreSrc_MEM, ALUResult_MEM, WriteData_MEM,
           PC4_MEM, ra_MEM
  );

  // Execute stage side
  modport slave (
    input  RegWrite_EX, Branch_EX, Jump_EX, rb1111check_EX, MemRW_EX,
           ALUSrc_EX, ResultSrc_EX, LoadStoreSrc_EX, ALUControl_EX,
           shift_amount_EX, BR_cond_EX, PC_EX, RD1_EX, RD2_EX, immExtend_EX,
           ra_EX, rb_EX, rac_EX, RegWrite_WB, ra_WB, Result_WB,
    output stall_EX, br_taken, br_target, RegWrite_MEM, MemRW_MEM,
           ResultSrc_MEM, LoadStoreSrc_MEM, ALUResult_MEM, WriteData_MEM,
           PC4_MEM, ra_MEM
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU/shifter, branch resolution, iterative 32-cycle multiplier.
// Latency: 1 cycle into EX/MEM; MUL holds EX for 34 cycles (33 stalled + 1 done).
// Backpressure: stall_EX freezes PC, IF/ID and ID/EX while the multiplier runs; EX/MEM gets bubbles.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input logic       CLK,
  input logic       RSTN,
  ex_stage_if.slave bus
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOTB = 4'b0101;
  localparam logic [3:0] ALU_SHR  = 4'b0110;
  localparam logic [3:0] ALU_SHRA = 4'b0111;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_ROR  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t    state;
  logic [31:0]   a_l, b_l, acc;
  logic [CW-1:0] cnt;

  logic [31:0] fwd_rb, fwd_rac;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_res;
  logic [4:0]  amt;
  logic [63:0] rot;
  logic        is_mul;
  logic        cond;
  logic        stall;

  // Forward rb: the younger MEM result wins over WB, register 0 is not special
  always_comb begin
    fwd_rb = bus.RD1_EX;
    if (bus.RegWrite_MEM && (bus.ra_MEM == bus.rb_EX))
      fwd_rb = bus.ALUResult_MEM;
    else if (bus.RegWrite_WB && (bus.ra_WB == bus.rb_EX))
      fwd_rb = bus.Result_WB;
  end

  // Forward rac with the same priority as rb
  always_comb begin
    fwd_rac = bus.RD2_EX;
    if (bus.RegWrite_MEM && (bus.ra_MEM == bus.rac_EX))
      fwd_rac = bus.ALUResult_MEM;
    else if (bus.RegWrite_WB && (bus.ra_WB == bus.rac_EX))
      fwd_rac = bus.Result_WB;
  end

  // Operand selection
  always_comb begin
    op_a = bus.rb1111check_EX ? 32'd0 : fwd_rb;
    case (bus.ALUSrc_EX)
      2'b00:   op_b = fwd_rac;
      2'b01:   op_b = bus.immExtend_EX;
      2'b10:   op_b = {26'd0, bus.shift_amount_EX};
      default: op_b = 32'd0;
    endcase
  end

  assign amt    = op_b[4:0];
  assign rot    = {op_a, op_a} >> amt;
  assign is_mul = (bus.ALUControl_EX == ALU_MUL);

  // Single-cycle ALU; MUL only yields the accumulator once the iteration is done
  always_comb begin
    alu_res = 32'd0;
    case (bus.ALUControl_EX)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOTB: alu_res = ~op_b;
      ALU_SHR:  alu_res = op_a >> amt;
      ALU_SHRA: alu_res = $unsigned($signed(op_a) >>> amt);
      ALU_SHL:  alu_res = op_a << amt;
      ALU_ROR:  alu_res = rot[31:0];
      ALU_MUL:  alu_res = (state == DONE) ? acc : 32'd0;
      default:  alu_res = 32'd0;
    endcase
  end

  // Branch condition on the forwarded rac value
  always_comb begin
    case (bus.BR_cond_EX)
      3'b001:  cond = 1'b1;
      3'b010:  cond = (fwd_rac == 32'd0);
      3'b011:  cond = (fwd_rac != 32'd0);
      3'b100:  cond = ~fwd_rac[31];
      3'b101:  cond = fwd_rac[31];
      default: cond = 1'b0;
    endcase
  end

  // Stall covers the launch cycle plus every shift-add iteration; gated off in reset
  assign stall         = RSTN & ((state == BUSY) || ((state == IDLE) && is_mul));
  assign bus.stall_EX  = stall;
  assign bus.br_taken  = RSTN & ~stall & (bus.Jump_EX | (bus.Branch_EX & cond));
  assign bus.br_target = bus.Jump_EX ? fwd_rb : (bus.PC_EX + bus.immExtend_EX);

  // Shift-add multiplier FSM; operands are latched at launch since MEM/WB drain during the stall
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      a_l   <= 32'd0;
      b_l   <= 32'd0;
      acc   <= 32'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            a_l   <= op_a;
            b_l   <= op_b;
            acc   <= 32'd0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (b_l[0]) acc <= acc + a_l;
          a_l <= a_l << 1;
          b_l <= b_l >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM register: a bubble while stalled, otherwise the executed instruction
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bus.RegWrite_MEM     <= 1'b0;
      bus.MemRW_MEM        <= 3'b000;
      bus.ResultSrc_MEM    <= 2'b00;
      bus.LoadStoreSrc_MEM <= 2'b00;
      bus.ALUResult_MEM    <= 32'd0;
      bus.WriteData_MEM    <= 32'd0;
      bus.PC4_MEM          <= 32'd0;
      bus.ra_MEM           <= 5'd0;
    end else if (stall) begin
      bus.RegWrite_MEM     <= 1'b0;
      bus.MemRW_MEM        <= 3'b000;
      bus.ResultSrc_MEM    <= 2'b00;
      bus.LoadStoreSrc_MEM <= 2'b00;
      bus.ALUResult_MEM    <= 32'd0;
      bus.WriteData_MEM    <= 32'd0;
      bus.PC4_MEM          <= 32'd0;
      bus.ra_MEM           <= 5'd0;
    end else begin
      bus.RegWrite_MEM     <= bus.RegWrite_EX;
      bus.MemRW_MEM        <= bus.MemRW_EX;
      bus.ResultSrc_MEM    <= bus.ResultSrc_EX;
      bus.LoadStoreSrc_MEM <= bus.LoadStoreSrc_EX;
      bus.ALUResult_MEM    <= alu_res;
      bus.WriteData_MEM    <= fwd_rac;
      bus.PC4_MEM          <= bus.PC_EX + 32'd4;
      bus.ra_MEM           <= bus.ra_EX;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU, shifts, branches, multiplier stall and reset.
// Latency: checks EX/MEM one edge after stimulus, combinational outputs at negedge.
// Backpressure: multiplier stall length and bubble insertion are measured directly.
module tb_ex_stage;

  logic clk;
  logic rstn;
  int   checks;
  int   fails;

  ex_stage_if bus ();

  ex_stage #(.MUL_CYCLES(32)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ALU vectors: A=0x0000F0F0, B=0x00000FF0
  logic [3:0]  alu_ctl [0:8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 4'hF, 4'hC};
  logic [31:0] alu_exp [0:8] = '{32'h0001_00E0, 32'h0000_E100, 32'h0000_00F0, 32'h0000_FFF0,
                                 32'h0000_FF00, 32'hFFFF_F00F, 32'h0, 32'h0, 32'h0};

  task automatic clr();
    bus.RegWrite_EX = 0; bus.Branch_EX = 0; bus.Jump_EX = 0; bus.rb1111check_EX = 0;
    bus.MemRW_EX = 0; bus.ALUSrc_EX = 0; bus.ResultSrc_EX = 0; bus.LoadStoreSrc_EX = 0;
    bus.ALUControl_EX = 4'hF; bus.shift_amount_EX = 0; bus.BR_cond_EX = 0;
    bus.PC_EX = 0; bus.RD1_EX = 0; bus.RD2_EX = 0; bus.immExtend_EX = 0;
    bus.ra_EX = 0; bus.rb_EX = 0; bus.rac_EX = 0;
    bus.RegWrite_WB = 0; bus.ra_WB = 0; bus.Result_WB = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches a MUL (called just after a posedge), counts stalled cycles and
  // non-bubble EX/MEM contents, returns just after the capturing edge.
  task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                         output int n, output int bad);
    bus.ALUControl_EX = 4'hA; bus.RD1_EX = a; bus.RD2_EX = b;
    bus.rb_EX = 5'd10; bus.rac_EX = 5'd11; bus.ALUSrc_EX = 2'b00;
    bus.rb1111check_EX = 0; bus.RegWrite_EX = 1; bus.ra_EX = 5'd5;
    n = 0;
    bad = 0;
    @(negedge clk);
    while (bus.stall_EX === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      if (bus.RegWrite_MEM !== 1'b0 || bus.ALUResult_MEM !== 32'd0) bad++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    rstn = 0;
    bus.ALUControl_EX = 4'hA;
    bus.Jump_EX = 1;
    #22;
    checks++; if (bus.stall_EX !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus.stall_EX); end
    checks++; if (bus.br_taken !== 1'b0) begin fails++; $display("FAIL reset_br_taken: got %b want 0", bus.br_taken); end
    checks++;
    if ({bus.RegWrite_MEM, bus.MemRW_MEM, bus.ResultSrc_MEM, bus.LoadStoreSrc_MEM, bus.ra_MEM} !== 13'd0 ||
        bus.ALUResult_MEM !== 0 || bus.WriteData_MEM !== 0 || bus.PC4_MEM !== 0) begin
      fails++; $display("FAIL reset_mem: ALUResult=%h PC4=%h RegWrite=%b want all 0",
                        bus.ALUResult_MEM, bus.PC4_MEM, bus.RegWrite_MEM);
    end
    clr();
    @(negedge clk);
    rstn = 1;
    tick();
  endtask

  task automatic test_forwarding();
    // ADD r1 = 0 + 5
    clr();
    bus.ALUControl_EX = 4'h0; bus.rb1111check_EX = 1; bus.ALUSrc_EX = 2'b01;
    bus.immExtend_EX = 32'd5; bus.RegWrite_EX = 1; bus.ra_EX = 5'd1;
    tick();
    checks++; if (bus.ALUResult_MEM !== 32'd5) begin fails++; $display("FAIL fwd_setup: got %h want 5", bus.ALUResult_MEM); end
    // ADD r2 = r1 + r1, MEM r1=5 beats WB r1=9
    bus.rb1111check_EX = 0; bus.ALUSrc_EX = 2'b00; bus.rb_EX = 5'd1; bus.rac_EX = 5'd1;
    bus.RD1_EX = 0; bus.RD2_EX = 0; bus.ra_EX = 5'd2; bus.PC_EX = 32'h0000_0200;
    bus.RegWrite_WB = 1; bus.ra_WB = 5'd1; bus.Result_WB = 32'd9;
    tick();
    checks++; if (bus.ALUResult_MEM !== 32'd10) begin fails++; $display("FAIL fwd_mem_priority: got %h want a", bus.ALUResult_MEM); end
    checks++; if (bus.WriteData_MEM !== 32'd5) begin fails++; $display("FAIL fwd_writedata: got %h want 5", bus.WriteData_MEM); end
    checks++; if (bus.PC4_MEM !== 32'h204 || bus.ra_MEM !== 5'd2) begin fails++; $display("FAIL fwd_pc4_ra: got %h/%0d want 204/2", bus.PC4_MEM, bus.ra_MEM); end
    // rb from WB (r3=9), rac from MEM (r2=10)
    bus.rb_EX = 5'd3; bus.rac_EX = 5'd2; bus.ra_WB = 5'd3; bus.ra_EX = 5'd4;
    tick();
    checks++; if (bus.ALUResult_MEM !== 32'd19) begin fails++; $display("FAIL fwd_wb_and_mem: got %h want 13", bus.ALUResult_MEM); end
    // no forwarding: register file values
    bus.RegWrite_WB = 0; bus.rb_EX = 5'd5; bus.rac_EX = 5'd6;
    bus.RD1_EX = 32'd100; bus.RD2_EX = 32'd23; bus.ra_EX = 5'd7;
    tick();
    checks++; if (bus.ALUResult_MEM !== 32'd123) begin fails++; $display("FAIL fwd_none: got %h want 7b", bus.ALUResult_MEM); end
  endtask

  task automatic test_alu();
    clr();
    bus.RD1_EX = 32'h0000_F0F0; bus.RD2_EX = 32'h0000_0FF0;
    bus.rb_EX = 5'd10; bus.rac_EX = 5'd11; bus.RegWrite_EX = 1; bus.ra_EX = 5'd31;
    for (int i = 0; i < 9; i++) begin
      bus.ALUControl_EX = alu_ctl[i];
      tick();
      checks++;
      if (bus.ALUResult_MEM !== alu_exp[i] || bus.RegWrite_MEM !== 1'b1) begin
        fails++; $display("FAIL alu_op_%h: got %h/%b want %h/1", alu_ctl[i], bus.ALUResult_MEM, bus.RegWrite_MEM, alu_exp[i]);
      end
    end
    // ALUSrc=11 forces B to zero
    bus.ALUControl_EX = 4'h0; bus.ALUSrc_EX = 2'b11;
    tick();
    checks++; if (bus.ALUResult_MEM !== 32'h0000_F0F0) begin fails++; $display("FAIL alu_srcb_zero: got %h want 0000f0f0", bus.ALUResult_MEM); end
    // bubble from ID/EX passes through
    clr();
    tick();
    checks++; if (bus.RegWrite_MEM !== 1'b0 || bus.ALUResult_MEM !== 32'd0) begin fails++; $display("FAIL alu_bubble: got %b/%h want 0/0", bus.RegWrite_MEM, bus.ALUResult_MEM); end
  endtask

  task automatic test_shifts();
    clr();
    bus.RD1_EX = 32'h8000_0000; bus.rb_EX = 5'd10; bus.ALUSrc_EX = 2'b10;
    bus.shift_amount_EX = 6'd4; bus.RegWrite_EX = 1; bus.ra_EX = 5'd31;
    bus.ALUControl_EX = 4'h7; tick();
    checks++; if (bus.ALUResult_MEM !== 32'hF800_0000) begin fails++; $display("FAIL shra: got %h want f8000000", bus.ALUResult_MEM); end
    bus.ALUControl_EX = 4'h6; tick();
    checks++; if (bus.ALUResult_MEM !== 32'h0800_0000) begin fails++; $display("FAIL shr: got %h want 08000000", bus.ALUResult_MEM); end
    bus.ALUControl_EX = 4'h9; tick();
    checks++; if (bus.ALUResult_MEM !== 32'h0800_0000) begin fails++; $display("FAIL ror: got %h want 08000000", bus.ALUResult_MEM); end
    bus.ALUControl_EX = 4'h8; tick();
    checks++; if (bus.ALUResult_MEM !== 32'h0) begin fails++; $display("FAIL shl_out: got %h want 0", bus.ALUResult_MEM); end
    bus.RD1_EX = 32'h0000_0013; bus.ALUControl_EX = 4'h9; tick();
    checks++; if (bus.ALUResult_MEM !== 32'h3000_0001) begin fails++; $display("FAIL ror_wrap: got %h want 30000001", bus.ALUResult_MEM); end
    // amount 36 uses only B[4:0] = 4
    bus.RD1_EX = 32'h8000_0000; bus.shift_amount_EX = 6'd36; bus.ALUControl_EX = 4'h6; tick();
    checks++; if (bus.ALUResult_MEM !== 32'h0800_0000) begin fails++; $display("FAIL shr_amt_mask: got %h want 08000000", bus.ALUResult_MEM); end
  endtask

  task automatic test_branch();
    clr();
    bus.Branch_EX = 1; bus.BR_cond_EX = 3'b010; bus.rac_EX = 5'd11; bus.rb_EX = 5'd10;
    bus.RD2_EX = 32'd0; bus.PC_EX = 32'h100; bus.immExtend_EX = 32'h20;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h120) begin fails++; $display("FAIL br_eqz_taken: got %b/%h want 1/120", bus.br_taken, bus.br_target); end
    bus.RD2_EX = 32'd3;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin fails++; $display("FAIL br_eqz_not_taken: got %b want 0", bus.br_taken); end
    bus.BR_cond_EX = 3'b011;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1) begin fails++; $display("FAIL br_nez: got %b want 1", bus.br_taken); end
    bus.BR_cond_EX = 3'b101; bus.RD2_EX = 32'h8000_0000;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1) begin fails++; $display("FAIL br_neg: got %b want 1", bus.br_taken); end
    bus.BR_cond_EX = 3'b100;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin fails++; $display("FAIL br_pos: got %b want 0", bus.br_taken); end
    bus.BR_cond_EX = 3'b110; bus.RD2_EX = 32'd0;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin fails++; $display("FAIL br_reserved: got %b want 0", bus.br_taken); end
    bus.Branch_EX = 0; bus.BR_cond_EX = 3'b001;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin fails++; $display("FAIL br_no_branch: got %b want 0", bus.br_taken); end
    bus.Jump_EX = 1; bus.BR_cond_EX = 3'b000; bus.RD1_EX = 32'h0000_4000;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h4000) begin fails++; $display("FAIL jump: got %b/%h want 1/4000", bus.br_taken, bus.br_target); end
    // a MUL launching in EX masks the jump; removed again before the edge
    bus.ALUControl_EX = 4'hA;
    #1;
    checks++; if (bus.stall_EX !== 1'b1 || bus.br_taken !== 1'b0) begin fails++; $display("FAIL jump_under_stall: got stall=%b taken=%b want 1/0", bus.stall_EX, bus.br_taken); end
    bus.ALUControl_EX = 4'hF;
    tick();
    clr();
  endtask

  task automatic test_mul();
    int n, bad;
    clr();
    mul_run(32'h0001_0003, 32'd7, n, bad);
    checks++; if (n !== 33) begin fails++; $display("FAIL mul_stall_len: got %0d want 33", n); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL mul_bubbles: got %0d non-bubbles want 0", bad); end
    checks++; if (bus.ALUResult_MEM !== 32'h0007_0015 || bus.RegWrite_MEM !== 1'b1 || bus.ra_MEM !== 5'd5) begin
      fails++; $display("FAIL mul_result: got %h/%b/%0d want 00070015/1/5", bus.ALUResult_MEM, bus.RegWrite_MEM, bus.ra_MEM);
    end
    // back-to-back MUL right after DONE: overflow case
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, n, bad);
    checks++; if (n !== 33) begin fails++; $display("FAIL mul_b2b_stall_len: got %0d want 33", n); end
    checks++; if (bus.ALUResult_MEM !== 32'h0000_0001 || bus.RegWrite_MEM !== 1'b1) begin
      fails++; $display("FAIL mul_overflow: got %h/%b want 00000001/1", bus.ALUResult_MEM, bus.RegWrite_MEM);
    end
    clr();
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int n, bad;
    clr();
    bus.ALUControl_EX = 4'hA; bus.RD1_EX = 32'h0001_0003; bus.RD2_EX = 32'd7;
    bus.rb_EX = 5'd10; bus.rac_EX = 5'd11; bus.RegWrite_EX = 1; bus.ra_EX = 5'd5;
    tick();
    repeat (9) @(posedge clk);
    #1;
    checks++; if (bus.stall_EX !== 1'b1) begin fails++; $display("FAIL mid_busy: got stall %b want 1", bus.stall_EX); end
    rstn = 0;
    #1;
    checks++; if (bus.stall_EX !== 1'b0) begin fails++; $display("FAIL mid_reset_stall: got %b want 0", bus.stall_EX); end
    checks++; if (bus.RegWrite_MEM !== 1'b0 || bus.ALUResult_MEM !== 0 || bus.PC4_MEM !== 0 || bus.ra_MEM !== 0) begin
      fails++; $display("FAIL mid_reset_mem: got %b/%h/%h/%0d want all 0", bus.RegWrite_MEM, bus.ALUResult_MEM, bus.PC4_MEM, bus.ra_MEM);
    end
    bus.ALUControl_EX = 4'hF;
    @(negedge clk);
    rstn = 1;
    tick();
    mul_run(32'h0001_0003, 32'd7, n, bad);
    checks++; if (n !== 33) begin fails++; $display("FAIL post_reset_stall_len: got %0d want 33", n); end
    checks++; if (bus.ALUResult_MEM !== 32'h0007_0015 || bad !== 0) begin
      fails++; $display("FAIL post_reset_mul: got %h bad=%0d want 00070015 bad=0", bus.ALUResult_MEM, bad);
    end
    clr();
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_forwarding();
    test_alu();
    test_shifts();
    test_branch();
    test_mul();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
